// File: rtl/multi_cycle_processor_if.sv
// Shared instruction/data memory port for multi_cycle_processor.
// Single req/ready handshake; the core is master, the memory is slave.
interface multi_cycle_processor_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/multi_cycle_processor.sv
// Multi-cycle RV32I-subset core with one shared memory port.
// FETCH/DECODE/EXEC/MEM/WB sequencing; sticky HALT on faults.
module multi_cycle_processor #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  multi_cycle_processor_if.master mem,
  output logic [XLEN-1:0]         pc_out,
  output logic                    retire,
  output logic                    halt
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] res_q;
  logic [XLEN-1:0] rf [32];

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opc = ir[6:0];
  assign f7  = ir[31:25];
  assign f3  = ir[14:12];
  assign rd  = ir[11:7];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];

  logic is_r;
  logic is_i;
  logic is_ld;
  logic is_st;
  logic is_br;
  logic is_jal;
  logic legal;

  assign is_r   = opc == OP_R;
  assign is_i   = opc == OP_I;
  assign is_ld  = opc == OP_LD;
  assign is_st  = opc == OP_ST;
  assign is_br  = opc == OP_BR;
  assign is_jal = opc == OP_JAL;

  // Legal opcode/funct3 combinations of the supported subset
  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      is_r: begin
        legal = (f3 inside {3'b000, 3'b010, 3'b011,
                            3'b100, 3'b110, 3'b111})
             && ((f7 == 7'h00)
             || (f7 == 7'h20 && f3 == 3'b000));
      end
      is_i: begin
        legal = f3 inside {3'b000, 3'b010, 3'b100,
                           3'b110, 3'b111};
      end
      is_ld, is_st: legal = f3 == 3'b010;
      is_br: begin
        legal = f3 inside {3'b000, 3'b001,
                           3'b100, 3'b101};
      end
      is_jal: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;

  // Immediate generator for I/S/B/J formats
  always_comb begin
    imm32 = {{20{ir[31]}}, ir[31:20]};
    unique case (1'b1)
      is_st: begin
        imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      is_br: begin
        imm32 = {{19{ir[31]}}, ir[31], ir[7],
                 ir[30:25], ir[11:8], 1'b0};
      end
      is_jal: begin
        imm32 = {{11{ir[31]}}, ir[31], ir[19:12],
                 ir[20], ir[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] alu_y;

  assign opb = is_r ? b_q : imm_q;

  // ALU for R-type and I-type arithmetic
  always_comb begin
    alu_y = a_q + opb;
    unique case (f3)
      3'b000: begin
        alu_y = (is_r && ir[30]) ? a_q - opb
                                 : a_q + opb;
      end
      3'b010: begin
        alu_y = XLEN'($signed(a_q) < $signed(opb));
      end
      3'b011: alu_y = XLEN'(a_q < opb);
      3'b100: alu_y = a_q ^ opb;
      3'b110: alu_y = a_q | opb;
      3'b111: alu_y = a_q & opb;
      default: ;
    endcase
  end

  logic            eq;
  logic            lt;
  logic            taken;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] ls_addr;

  assign eq = a_q == b_q;
  assign lt = $signed(a_q) < $signed(b_q);

  // Branch condition select
  always_comb begin
    taken = 1'b0;
    unique case (f3)
      3'b000: taken = eq;
      3'b001: taken = !eq;
      3'b100: taken = lt;
      3'b101: taken = !lt;
      default: taken = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + XLEN'(4);
  assign pc_imm   = pc + imm_q;
  assign br_tgt   = taken ? pc_imm : pc_plus4;
  assign ls_addr  = a_q + imm_q;

  // Main sequencer: state, PC, IR, operands, register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      imm_q  <= '0;
      addr_q <= '0;
      res_q  <= '0;
      retire <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else begin
      retire <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (mem.mem_ready) begin
            ir    <= mem.mem_rdata[31:0];
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q   <= rf[rs1];
          b_q   <= rf[rs2];
          imm_q <= imm_ext;
          state <= legal ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          unique case (1'b1)
            is_ld, is_st: begin
              if (ls_addr[1:0] != 2'b00) begin
                state <= S_HALT;
              end else begin
                addr_q <= ls_addr;
                state  <= S_MEM;
              end
            end
            is_br: begin
              if (br_tgt[1:0] != 2'b00) begin
                state <= S_HALT;
              end else begin
                pc     <= br_tgt;
                retire <= 1'b1;
                state  <= S_FETCH;
              end
            end
            is_jal: begin
              if (pc_imm[1:0] != 2'b00) begin
                state <= S_HALT;
              end else begin
                res_q <= pc_plus4;
                pc    <= pc_imm;
                state <= S_WB;
              end
            end
            default: begin
              res_q <= alu_y;
              state <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (mem.mem_ready) begin
            if (is_st) begin
              pc     <= pc_plus4;
              retire <= 1'b1;
              state  <= S_FETCH;
            end else begin
              res_q <= mem.mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (rd != 5'd0) begin
            rf[rd] <= res_q;
          end
          if (!is_jal) begin
            pc <= pc_plus4;
          end
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  assign mem.mem_req   = rst
                      && (state == S_FETCH
                      || state == S_MEM);
  assign mem.mem_we    = (state == S_MEM) && is_st;
  assign mem.mem_addr  = (state == S_MEM) ? addr_q : pc;
  assign mem.mem_wdata = b_q;
  assign pc_out        = pc;
  assign halt          = state == S_HALT;

endmodule

// File: tb/tb_multi_cycle_processor.sv
// Bench for multi_cycle_processor: memory model plus
// retire/store scoreboards fed by the program builder.
module tb_multi_cycle_processor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_out;
  logic        retire;
  logic        halt;

  multi_cycle_processor_if #(.XLEN(32)) bus ();

  multi_cycle_processor #(
    .XLEN    (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .mem   (bus),
    .pc_out(pc_out),
    .retire(retire),
    .halt  (halt)
  );

  typedef struct {
    int          c;
    logic [31:0] pc;
  } ret_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  logic [31:0] mem [128];
  ret_t        ret_q [$];
  st_t         st_q [$];
  int          stall_left;
  int          pend_stall;
  int          cyc;
  int          exp_cyc;
  int          n_chk;
  int          n_pass;

  assign bus.mem_ready = (stall_left == 0);
  assign bus.mem_rdata = mem[bus.mem_addr[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h",
                  tag, obs, exp);
  endtask

  function automatic logic [31:0] i_t(
    logic [2:0] f3, int rd, int rs1, int imm,
    logic [6:0] op = 7'h13);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] lw_t(
    int rd, int rs1, int imm);
    return i_t(3'b010, rd, rs1, imm, 7'h03);
  endfunction

  function automatic logic [31:0] r_t(
    logic [6:0] f7, logic [2:0] f3,
    int rd, int rs1, int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] s_t(
    int rs1, int rs2, int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010,
            im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(
    logic [2:0] f3, int rs1, int rs2, int imm);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3,
            im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(int rd, int imm);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12],
            5'(rd), 7'h6F};
  endfunction

  task automatic put(int a, logic [31:0] w);
    mem[a >> 2] = w;
  endtask

  task automatic ins(int a, logic [31:0] w,
                     int lat, int npc);
    put(a, w);
    exp_cyc += lat;
    ret_q.push_back('{exp_cyc, 32'(npc)});
  endtask

  task automatic exp_st(int a, logic [31:0] d);
    st_q.push_back('{32'(a), d});
  endtask

  task automatic begin_test(int stall);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    ret_q.delete();
    st_q.delete();
    exp_cyc    = stall;
    pend_stall = stall;
  endtask

  task automatic go();
    #1;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_halt", halt, 0);
    chk("rst_retire", retire, 0);
    stall_left = pend_stall;
    @(negedge clk);
    #2;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic run_to_halt(int budget, int exp_pc);
    int n;
    n = 0;
    while (!halt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halted", halt, 1);
    repeat (4) @(negedge clk);
    chk("end_pc", pc_out, 32'(exp_pc));
    chk("ret_left", 32'(ret_q.size()), 0);
    chk("st_left", 32'(st_q.size()), 0);
  endtask

  // Sample outputs mid-cycle: stalls, stores, retires, halt
  always @(negedge clk) begin
    ret_t r;
    st_t  s;
    if (rst) begin
      cyc++;
      if (stall_left > 0) begin
        chk("stall_req", bus.mem_req, 1);
        chk("stall_addr", bus.mem_addr, 0);
        stall_left--;
      end
      if (bus.mem_req && bus.mem_we && bus.mem_ready) begin
        if (st_q.size() == 0) begin
          chk("st_extra", 32'(st_q.size()), 1);
        end else begin
          s = st_q.pop_front();
          chk("st_addr", bus.mem_addr, s.a);
          chk("st_data", bus.mem_wdata, s.d);
          mem[bus.mem_addr[8:2]] = bus.mem_wdata;
        end
      end
      if (retire) begin
        if (ret_q.size() == 0) begin
          chk("ret_extra", 32'(ret_q.size()), 1);
        end else begin
          r = ret_q.pop_front();
          chk("ret_cyc", 32'(cyc), 32'(r.c));
          chk("ret_pc", pc_out, r.pc);
        end
      end
      if (halt) begin
        chk("halt_req", bus.mem_req, 0);
        chk("halt_ret", retire, 0);
      end
    end
  end

  initial begin
    rst        = 1'b0;
    stall_left = 0;
    pend_stall = 0;
    cyc        = 0;
    exp_cyc    = 0;
    n_chk      = 0;
    n_pass     = 0;

    // ALU, load/store, branches, jumps, x0, wrap
    begin_test(0);
    put(32'h1C0, 32'hDEADBEEF);
    ins(0,   i_t(0, 1, 0, 5), 4, 4);
    ins(4,   i_t(0, 2, 0, -3), 4, 8);
    ins(8,   r_t(0, 0, 3, 1, 2), 4, 12);
    ins(12,  s_t(0, 3, 'h100), 4, 16);
    exp_st('h100, 32'd2);
    ins(16,  lw_t(4, 0, 'h1C0), 5, 20);
    ins(20,  s_t(0, 4, 'h104), 4, 24);
    exp_st('h104, 32'hDEADBEEF);
    ins(24,  lw_t(9, 0, 'h104), 5, 28);
    ins(28,  s_t(0, 9, 'h108), 4, 32);
    exp_st('h108, 32'hDEADBEEF);
    ins(32,  i_t(0, 5, 0, -1), 4, 36);
    ins(36,  i_t(0, 6, 0, 1), 4, 40);
    ins(40,  r_t(0, 3'b010, 7, 5, 6), 4, 44);
    ins(44,  r_t(0, 3'b011, 8, 5, 6), 4, 48);
    ins(48,  s_t(0, 7, 'h10C), 4, 52);
    exp_st('h10C, 32'd1);
    ins(52,  s_t(0, 8, 'h110), 4, 56);
    exp_st('h110, 32'd0);
    ins(56,  i_t(0, 0, 0, 7), 4, 60);
    ins(60,  s_t(0, 0, 'h114), 4, 64);
    exp_st('h114, 32'd0);
    ins(64,  r_t(7'h20, 0, 10, 1, 2), 4, 68);
    ins(68,  r_t(0, 3'b100, 11, 10, 2), 4, 72);
    ins(72,  i_t(3'b111, 12, 11, 'hF0), 4, 76);
    ins(76,  i_t(3'b110, 12, 12, 1), 4, 80);
    ins(80,  s_t(0, 12, 'h118), 4, 84);
    exp_st('h118, 32'hF1);
    ins(84,  s_t(0, 11, 'h11C), 4, 88);
    exp_st('h11C, 32'hFFFFFFF5);
    ins(88,  b_t(3'b001, 0, 0, 8), 3, 92);
    ins(92,  b_t(3'b000, 0, 0, 8), 3, 100);
    put(96,  32'h7F);
    ins(100, j_t(13, 16), 4, 116);
    put(104, 32'h7F);
    put(108, 32'h7F);
    put(112, 32'h7F);
    ins(116, s_t(0, 13, 'h120), 4, 120);
    exp_st('h120, 32'd104);
    ins(120, b_t(3'b100, 5, 6, 8), 3, 128);
    put(124, 32'h7F);
    ins(128, b_t(3'b101, 5, 6, 8), 3, 132);
    ins(132, j_t(0, 12), 4, 144);
    put(136, 32'h7F);
    ins(144, b_t(3'b000, 0, 0, -4), 3, 140);
    ins(140, j_t(0, 12), 4, 152);
    put(148, 32'h7F);
    ins(152, r_t(0, 3'b111, 15, 1, 11), 4, 156);
    ins(156, r_t(0, 3'b110, 16, 15, 10), 4, 160);
    ins(160, s_t(0, 16, 'h124), 4, 164);
    exp_st('h124, 32'hD);
    ins(164, r_t(0, 0, 18, 5, 6), 4, 168);
    ins(168, i_t(3'b010, 17, 5, 0), 4, 172);
    ins(172, i_t(3'b100, 17, 17, -1), 4, 176);
    ins(176, r_t(0, 0, 17, 17, 18), 4, 180);
    ins(180, s_t(0, 17, 'h128), 4, 184);
    exp_st('h128, 32'hFFFFFFFE);
    ins(184, b_t(3'b101, 6, 5, 8), 3, 192);
    put(188, 32'h7F);
    put(192, 32'h7F);
    go();
    run_to_halt(400, 192);

    // Fetch wait states, then misaligned load
    begin_test(3);
    ins(0, i_t(0, 1, 0, 5), 4, 4);
    ins(4, s_t(0, 1, 'h100), 4, 8);
    exp_st('h100, 32'd5);
    put(8, lw_t(2, 0, 6));
    go();
    run_to_halt(100, 8);

    // Misaligned jump target
    begin_test(0);
    ins(0, i_t(0, 1, 0, 1), 4, 4);
    put(4, j_t(0, 2));
    go();
    run_to_halt(100, 4);

    // Reset during a store access
    begin_test(0);
    put(0, s_t(0, 0, 'h100));
    exp_st('h100, 32'd0);
    go();
    repeat (3) @(negedge clk);
    #1;
    chk("st_we", bus.mem_we, 1);
    rst = 1'b0;
    #1;
    chk("abort_req", bus.mem_req, 0);
    chk("abort_we", bus.mem_we, 0);
    chk("abort_pc", pc_out, 0);
    chk("abort_st", 32'(st_q.size()), 0);

    // Reset during a stalled fetch
    begin_test(5);
    put(0, i_t(0, 1, 0, 5));
    go();
    repeat (2) @(negedge clk);
    #1;
    chk("fetch_req", bus.mem_req, 1);
    rst = 1'b0;
    #1;
    chk("fabort_req", bus.mem_req, 0);
    chk("fabort_pc", pc_out, 0);
    chk("fabort_ret", 32'(ret_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_cycle_processor.md
Name: multi_cycle_processor

Overview:
- Parametrised multi-cycle successor to the single-cycle core: RV32I-style integer subset, XLEN-wide datapath.
- Internal register file, ALU, immediate generator and PC.
- One shared instruction/data memory port with a req/ready handshake, so memory may insert wait states.
- FSM-sequenced with a halt state; sits between the testbench/SoC memory model and nothing else.

Parameters:
XLEN, 32, datapath, register and address width (≥32; immediates sign-extended to XLEN).
RESET_PC, 0, PC value loaded on reset (must be 4-aligned).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
mem_req  out  1  memory request valid.
mem_we  out  1  1 = store, 0 = read (fetch or load).
mem_addr  out  XLEN  byte address, word accesses only.
mem_wdata  out  XLEN  store data (rs2 value).
mem_ready  in  1  access completes on the rising edge where mem_req=1 and mem_ready=1.
mem_rdata  in  XLEN  read data, valid when mem_ready=1.
pc_out  out  XLEN  current PC.
retire  out  1  one-cycle pulse per completed instruction.
halt  out  1  core halted; sticky until reset.

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, x0..x31=0, state=FETCH, IR=0, halt=0, retire=0. mem_req drops combinationally, mem_we=0, mem_addr=RESET_PC.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=PC.
  - Holds req and addr stable until the ready edge, then IR<=mem_rdata and goes to DECODE. A request is never retracted.
- DECODE:
  - Latches A=rs1 and B=rs2 from the register file and forms the sign-extended immediate (I/S/B/J formats).
  - Goes to EXEC.
  - Unsupported opcode or funct3 goes to HALT.
- EXEC:
  - R-type (ADD, SUB via instr[30], AND, OR, XOR, SLT signed, SLTU): result=A op B, then WB.
  - I-type ALU (ADDI, ANDI, ORI, XORI, SLTI): result=A op imm, then WB.
  - LW/SW: addr=A+imm, then MEM.
  - BEQ/BNE/BLT/BGE: taken gives PC<=PC+imm, otherwise PC<=PC+4. Retire pulses and the FSM returns to FETCH.
  - JAL: result=PC+4 and PC<=PC+imm, then WB.
- MEM:
  - Drives mem_req=1, mem_addr=addr, mem_we=1 for SW with mem_wdata=B.
  - Waits for ready, holding all outputs stable.
  - LW: MDR<=mem_rdata, then WB.
  - SW: PC<=PC+4, retire, then FETCH.
- WB:
  - Writes result (or MDR for a load) to rd unless rd=0; x0 always reads 0.
  - Non-JAL instructions set PC<=PC+4.
  - Retire pulses, then FETCH.
- Misalignment: any PC update whose target[1:0]≠0, or a LW/SW address with [1:0]≠0, goes to HALT. No memory request is issued, no register is written, retire does not pulse, and PC keeps its old value.
- HALT: halt=1, mem_req=0; the core stays halted until reset.
- Arithmetic: all adds wrap modulo 2^XLEN; no overflow detection.
- Latency with zero-wait memory (ready in the same cycle as req):
  - ALU and JAL: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle on mem_ready adds 1.
- retire is asserted in the final cycle of the instruction (registered, 1 cycle wide); never asserted in HALT.
- Reset asserted mid-FETCH or mid-MEM aborts the access immediately. A store in progress is not completed unless its ready edge already occurred.

Test Plan:
- Zero-wait memory, program ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 -> x3=2. retire pulses at cycles 4, 8, 12 after reset release; PC=12.
- mem_ready held low for 3 cycles during the first fetch -> mem_req and mem_addr=0 stable all 3 cycles, IR captured on the ready edge, first retire at cycle 7.
- SW x1,8(x0) with x1=0xDEADBEEF, then LW x4,8(x0) -> one write with mem_addr=8, mem_wdata=0xDEADBEEF, mem_we=1; x4=0xDEADBEEF; the load takes 5 cycles.
- BEQ x0,x0,-4 at PC=8 -> PC=4 after 3 cycles. BNE x0,x0,+8 -> PC=PC+4. JAL x1,+16 at PC=0 -> x1=4, PC=16.
- ADDI x0,x0,7 -> x0 reads 0. SLT with A=0xFFFFFFFF, B=1 gives 1; SLTU with the same operands gives 0.
- Each of these goes to HALT: illegal opcode 0x0000007F, LW with address 0x6, and JAL +2. halt=1, mem_req=0 thereafter, retire silent. Dropping rst in a later cycle restores PC=RESET_PC and halt=0.
